// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter checker:
// error codes and the lock-tracking FSM states.
package ring_pkg;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ZERO  = 2'd1;
    localparam logic [1:0] ERR_MULTI = 2'd2;
    localparam logic [1:0] ERR_STEP  = 2'd3;

    typedef enum logic [1:0] {
        HUNT,
        LOCKING,
        LOCKED
    } state_t;

endpackage

// File: rtl/ring_counter_checker_if.sv
// Monitored ring bus plus checker status outputs.
// master: the side feeding samples; slave: the checker.
interface ring_counter_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);

    localparam int IW = $clog2(WIDTH);

    logic                 en;
    logic [WIDTH-1:0]     q_in;
    logic                 clr_err;
    logic [IW-1:0]        idx;
    logic                 idx_valid;
    logic                 locked;
    logic                 err_pulse;
    logic [1:0]           err_code;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output en, q_in, clr_err,
        input  idx, idx_valid, locked,
        input  err_pulse, err_code,
        input  err_sticky, err_cnt
    );

    modport slave (
        input  en, q_in, clr_err,
        output idx, idx_valid, locked,
        output err_pulse, err_code,
        output err_sticky, err_cnt
    );

endinterface

// File: rtl/onehot_decode.sv
// Combinational one-hot to binary decoder that also
// flags the all-zero and multi-hot cases.
module onehot_decode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         q_in,
    output logic [$clog2(WIDTH)-1:0] idx_new,
    output logic                     is_zero,
    output logic                     is_multi
);

    localparam int IW = $clog2(WIDTH);

    logic seen;

    // OR together the positions of set bits; a second set bit marks multi-hot
    always_comb begin
        idx_new  = '0;
        seen     = 1'b0;
        is_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_in[i]) begin
                if (seen) begin
                    is_multi = 1'b1;
                end
                seen    = 1'b1;
                idx_new = idx_new | IW'(i);
            end
        end
        is_zero = ~seen;
    end

endmodule

// File: rtl/ring_counter_checker.sv
// One-hot ring counter monitor: decodes each enabled sample,
// checks left rotation, tracks lock and error statistics.
module ring_counter_checker
    import ring_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ring_counter_checker_if.slave  bus
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = $clog2(LOCK_COUNT + 1);

    localparam logic [IW-1:0]        LAST_IDX = IW'(WIDTH - 1);
    localparam logic [SW-1:0]        LOCK_N   = SW'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic [IW-1:0]        prev_q, prev_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [1:0]           code_q, code_d;
    logic                 pulse_q;
    logic                 sticky_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    logic [IW-1:0]        idx_new;
    logic                 is_zero;
    logic                 is_multi;
    logic [IW-1:0]        want_idx;
    logic                 step_ok;
    logic [SW-1:0]        streak_inc;
    logic                 err;
    logic [1:0]           err_type;
    logic [ERR_CNT_W-1:0] cnt_base;
    logic [ERR_CNT_W-1:0] cnt_inc;

    onehot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .q_in     (bus.q_in),
        .idx_new  (idx_new),
        .is_zero  (is_zero),
        .is_multi (is_multi)
    );

    assign want_idx   = (prev_q == LAST_IDX) ? '0 : prev_q + IW'(1);
    assign step_ok    = (idx_new == want_idx);
    assign streak_inc = streak_q + SW'(1);

    // Clear takes effect first so a simultaneous error restarts the count at 1
    assign cnt_base = bus.clr_err ? '0 : cnt_q;
    assign cnt_inc  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + ERR_CNT_W'(1);

    // Classify the sample and advance the lock FSM
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        streak_d = streak_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        code_d   = code_q;
        err      = 1'b0;
        err_type = ERR_NONE;
        if (bus.en) begin
            if (is_zero || is_multi) begin
                err      = 1'b1;
                err_type = is_zero ? ERR_ZERO : ERR_MULTI;
                valid_d  = 1'b0;
                state_d  = HUNT;
                streak_d = '0;
            end else begin
                idx_d   = idx_new;
                valid_d = 1'b1;
                prev_d  = idx_new;
                unique case (state_q)
                    HUNT: begin
                        state_d  = LOCKING;
                        streak_d = '0;
                    end
                    LOCKING: begin
                        if (step_ok) begin
                            streak_d = streak_inc;
                            if (streak_inc == LOCK_N) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            err      = 1'b1;
                            err_type = ERR_STEP;
                            streak_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            err      = 1'b1;
                            err_type = ERR_STEP;
                            state_d  = LOCKING;
                            streak_d = '0;
                        end
                    end
                    default: begin
                        state_d  = HUNT;
                        streak_d = '0;
                    end
                endcase
            end
            code_d = err ? err_type : ERR_NONE;
        end
    end

    // FSM state, anchor index and decoded outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            streak_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            streak_q <= streak_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
        end
    end

    // Error pulse, sticky flag and saturating error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pulse_q <= err;
            if (err) begin
                sticky_q <= 1'b1;
                cnt_q    <= cnt_inc;
            end else if (bus.clr_err) begin
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end
        end
    end

    assign bus.idx        = idx_q;
    assign bus.idx_valid  = valid_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.err_pulse  = pulse_q;
    assign bus.err_code   = code_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = cnt_q;

endmodule

// File: tb/tb_ring_counter_checker.sv
// Self-checking bench: behavioural model feeds a scoreboard,
// plus directed checks for each scenario.
module tb_ring_counter_checker;

    localparam int LOCK_COUNT = 3;

    typedef struct {
        logic [1:0] idx;
        logic       idx_valid;
        logic       locked;
        logic       err_pulse;
        logic [1:0] err_code;
        logic       err_sticky;
        logic [7:0] err_cnt;
        logic [1:0] cnt2;
    } exp_t;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    exp_t q_exp[$];
    exp_t m;
    exp_t e;

    int         m_state;
    logic [3:0] m_prevq;
    int         m_streak;
    int         m_cnt;
    int         m_cnt2;

    ring_counter_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();
    ring_counter_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus2 ();

    ring_counter_checker #(
        .WIDTH(4), .LOCK_COUNT(LOCK_COUNT), .ERR_CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ring_counter_checker #(
        .WIDTH(4), .LOCK_COUNT(LOCK_COUNT), .ERR_CNT_W(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state  = 0;
        m_prevq  = 4'b0001;
        m_streak = 0;
        m_cnt    = 0;
        m_cnt2   = 0;
        m.idx        = 2'd0;
        m.idx_valid  = 1'b0;
        m.locked     = 1'b0;
        m.err_pulse  = 1'b0;
        m.err_code   = 2'd0;
        m.err_sticky = 1'b0;
        m.err_cnt    = 8'd0;
        m.cnt2       = 2'd0;
    endtask

    task automatic model(input logic en, input logic [3:0] q, input logic clr);
        int   ones;
        bit   err;
        bit   ok;
        logic [1:0] code;
        ones = $countones(q);
        err  = 0;
        code = 2'd0;
        m.err_pulse = 1'b0;
        if (en) begin
            if (ones != 1) begin
                err  = 1;
                code = (ones == 0) ? 2'd1 : 2'd2;
                m.idx_valid = 1'b0;
                m_state  = 0;
                m_streak = 0;
            end else begin
                ok = (q == {m_prevq[2:0], m_prevq[3]});
                for (int i = 0; i < 4; i++) begin
                    if (q[i]) m.idx = 2'(i);
                end
                m.idx_valid = 1'b1;
                if (m_state == 0) begin
                    m_state  = 1;
                    m_streak = 0;
                end else if (ok) begin
                    if (m_state == 1) begin
                        m_streak++;
                        if (m_streak == LOCK_COUNT) m_state = 2;
                    end
                end else begin
                    err      = 1;
                    code     = 2'd3;
                    m_state  = 1;
                    m_streak = 0;
                end
                m_prevq = q;
            end
            m.err_code = code;
        end
        if (clr) begin
            m.err_sticky = 1'b0;
            m_cnt  = 0;
            m_cnt2 = 0;
        end
        if (err) begin
            m.err_pulse  = 1'b1;
            m.err_sticky = 1'b1;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        m.locked  = (m_state == 2);
        m.err_cnt = 8'(m_cnt);
        m.cnt2    = 2'(m_cnt2);
    endtask

    task automatic drive(input logic en, input logic [3:0] q, input logic clr);
        bus.en       = en;
        bus.q_in     = q;
        bus.clr_err  = clr;
        bus2.en      = en;
        bus2.q_in    = q;
        bus2.clr_err = clr;
        model(en, q, clr);
        q_exp.push_back(m);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: compare each registered result one step after its edge
    always @(posedge clk) begin
        #1;
        if (!rst && q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if ({bus.idx, bus.idx_valid, bus.locked} !== {e.idx, e.idx_valid, e.locked}) begin
                n_fail++;
                $display("FAIL sb_decode got idx=%0d v=%0b lk=%0b want idx=%0d v=%0b lk=%0b",
                         bus.idx, bus.idx_valid, bus.locked, e.idx, e.idx_valid, e.locked);
            end
            n_checks++;
            if ({bus.err_pulse, bus.err_code, bus.err_sticky} !== {e.err_pulse, e.err_code, e.err_sticky}) begin
                n_fail++;
                $display("FAIL sb_err got p=%0b c=%0d s=%0b want p=%0b c=%0d s=%0b",
                         bus.err_pulse, bus.err_code, bus.err_sticky,
                         e.err_pulse, e.err_code, e.err_sticky);
            end
            n_checks++;
            if ({bus.err_cnt, bus2.err_cnt} !== {e.err_cnt, e.cnt2}) begin
                n_fail++;
                $display("FAIL sb_cnt got %0d/%0d want %0d/%0d",
                         bus.err_cnt, bus2.err_cnt, e.err_cnt, e.cnt2);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        n_checks++;
        if ({bus.idx, bus.idx_valid, bus.locked, bus.err_pulse} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_decode got %b want 00000",
                     {bus.idx, bus.idx_valid, bus.locked, bus.err_pulse});
        end
        n_checks++;
        if ({bus.err_code, bus.err_sticky, bus.err_cnt, bus2.err_cnt} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_err got code=%0d s=%0b cnt=%0d want 0",
                     bus.err_code, bus.err_sticky, bus.err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic drive_idle();
        bus.en       = 1'b0;
        bus.q_in     = 4'b0;
        bus.clr_err  = 1'b0;
        bus2.en      = 1'b0;
        bus2.q_in    = 4'b0;
        bus2.clr_err = 1'b0;
    endtask

    task automatic test_rotate();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] xidx[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       xlk [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            n_checks++;
            if ({bus.idx, bus.locked} !== {xidx[i], xlk[i]}) begin
                n_fail++;
                $display("FAIL rotate_%0d got idx=%0d lk=%0b want idx=%0d lk=%0b",
                         i, bus.idx, bus.locked, xidx[i], xlk[i]);
            end
        end
        n_checks++;
        if (bus.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rotate_cnt got %0d want 0", bus.err_cnt);
        end
    endtask

    task automatic test_stuck_zero();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b0);
            if (bus.err_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 5) begin
            n_fail++;
            $display("FAIL zero_pulses got %0d want 5", pulses);
        end
        n_checks++;
        if ({bus.err_code, bus.err_cnt, bus.locked, bus.idx_valid} !== {2'd1, 8'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_state got code=%0d cnt=%0d lk=%0b v=%0b want 1 5 0 0",
                     bus.err_code, bus.err_cnt, bus.locked, bus.idx_valid);
        end
    endtask

    task automatic test_step_err();
        logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
        drive(1'b1, 4'b1000, 1'b0);
        n_checks++;
        if ({bus.err_code, bus.err_pulse, bus.locked} !== {2'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL step_jump got code=%0d p=%0b lk=%0b want 3 1 0",
                     bus.err_code, bus.err_pulse, bus.locked);
        end
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0010, 1'b0);
        n_checks++;
        if (bus.locked !== 1'b0) begin
            n_fail++;
            $display("FAIL step_early got lk=%0b want 0", bus.locked);
        end
        drive(1'b1, 4'b0100, 1'b0);
        n_checks++;
        if ({bus.locked, bus.err_code} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL step_relock got lk=%0b code=%0d want 1 0",
                     bus.locked, bus.err_code);
        end
        drive(1'b1, 4'b0100, 1'b0);
        n_checks++;
        if ({bus.err_code, bus.locked} !== {2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL step_stall got code=%0d lk=%0b want 3 0",
                     bus.err_code, bus.locked);
        end
    endtask

    task automatic test_multi();
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
        drive(1'b1, 4'b0110, 1'b0);
        n_checks++;
        if ({bus.err_code, bus.idx, bus.locked, bus.idx_valid} !== {2'd2, 2'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL multi got code=%0d idx=%0d lk=%0b v=%0b want 2 3 0 0",
                     bus.err_code, bus.idx, bus.locked, bus.idx_valid);
        end
    endtask

    task automatic test_en_toggle();
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] junk[3] = '{4'b0000, 4'b0110, 4'b0100};
        logic [7:0] cnt0;
        foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
        cnt0 = bus.err_cnt;
        foreach (junk[i]) begin
            drive(1'b0, junk[i], 1'b0);
            n_checks++;
            if ({bus.err_pulse, bus.idx, bus.locked, bus.err_cnt} !== {1'b0, 2'd3, 1'b1, cnt0}) begin
                n_fail++;
                $display("FAIL en_hold_%0d got p=%0b idx=%0d lk=%0b cnt=%0d want 0 3 1 %0d",
                         i, bus.err_pulse, bus.idx, bus.locked, bus.err_cnt, cnt0);
            end
        end
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 1'b1);
        n_checks++;
        if ({bus.err_cnt, bus.err_sticky} !== {8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_and_err got cnt=%0d s=%0b want 1 1",
                     bus.err_cnt, bus.err_sticky);
        end
        drive(1'b0, 4'b0000, 1'b1);
        n_checks++;
        if ({bus.err_cnt, bus.err_sticky} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_only got cnt=%0d s=%0b want 0 0",
                     bus.err_cnt, bus.err_sticky);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b0000, 1'b0);
        n_checks++;
        if ({bus2.err_cnt, bus.err_cnt} !== {2'd3, 8'd5}) begin
            n_fail++;
            $display("FAIL saturate got %0d/%0d want 3/5", bus2.err_cnt, bus.err_cnt);
        end
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0010, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.idx, bus.idx_valid, bus.locked, bus.err_pulse, bus.err_code,
             bus.err_sticky, bus.err_cnt, bus2.err_cnt} !== 17'b0) begin
            n_fail++;
            $display("FAIL async_rst got idx=%0d v=%0b s=%0b cnt=%0d want all 0",
                     bus.idx, bus.idx_valid, bus.err_sticky, bus.err_cnt);
        end
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] r;
        logic [3:0] q;
        int sel;
        r = 4'b0001;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                q = r;
                r = {r[2:0], r[3]};
            end else if (sel == 7) begin
                q = 4'($urandom_range(0, 15));
            end else if (sel == 8) begin
                q = {r[0], r[3:1]};
            end else begin
                q = 4'b0000;
            end
            drive($urandom_range(0, 4) != 0, q, $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        test_reset();
        test_rotate();
        test_stuck_zero();
        test_step_err();
        test_multi();
        test_en_toggle();
        test_saturate();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #2;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_counter_checker.md
Name: ring_counter_checker

Overview:
- Receive-side monitor for a one-hot ring counter bus.
- Samples the counter state on each enabled clock, decodes the one-hot value to a binary index, and checks that each step rotates left by one position.
- Detects the illegal all-zero state, multi-hot states and wrong steps, and maintains lock status plus error statistics.
- Sits beside any ring counter instance as a checker/decoder; its outputs feed status registers and the bench scoreboard.

Parameters:
- WIDTH, 4: ring width in bits (≥2).
- LOCK_COUNT, 3: consecutive correct steps required to declare lock (≥1).
- ERR_CNT_W, 8: error counter width; the counter saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  sample qualifier; q_in is evaluated only when en=1
- q_in  input  WIDTH  observed ring counter state
- clr_err  input  1  synchronous clear of err_sticky and err_cnt
- idx  output  $clog2(WIDTH)  binary position of the set bit in the last valid sample
- idx_valid  output  1  last sample was a legal one-hot value
- locked  output  1  ring verified rotating correctly
- err_pulse  output  1  one-cycle pulse when the sampled value is erroneous
- err_code  output  2  0=none, 1=ZERO, 2=MULTI, 3=STEP; holds its value until the next sample
- err_sticky  output  1  set by any error, cleared by clr_err or rst
- err_cnt  output  ERR_CNT_W  saturating error count

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, FSM=HUNT, prev_idx=0, streak=0. Reset asserted mid-operation forces these values immediately, regardless of en or clr_err.
- All outputs are registered. Latency is one cycle: a sample taken at edge N is reflected after edge N.
- When en=0: FSM, idx, idx_valid, err_code, prev_idx and streak hold; err_pulse=0.
- Classification of each sample:
  - ZERO: q_in==0.
  - MULTI: popcount(q_in)>1.
  - ONEHOT: otherwise.
  - A one-hot sample is correct when idx_new == (prev_idx+1) mod WIDTH, i.e. q_next = {q[WIDTH-2:0], q[WIDTH-1]}. Wrap from bit WIDTH-1 to bit 0 is a correct step.
- On a ONEHOT sample: idx<=idx_new, idx_valid<=1, prev_idx<=idx_new.
- On a ZERO or MULTI sample: idx holds, idx_valid<=0, prev_idx holds.
- FSM, per enabled sample:
  - HUNT: ONEHOT → LOCKING, streak=0, no error. ZERO/MULTI → stay in HUNT and flag the error.
  - LOCKING: correct step → streak+1; if streak+1==LOCK_COUNT → LOCKED. Wrong one-hot → flag STEP, stay in LOCKING, streak=0, re-anchor on the new index. ZERO/MULTI → flag the error, go to HUNT.
  - LOCKED: correct step → stay. Any error → flag it, clear locked, go to HUNT. A wrong one-hot re-anchors and enters LOCKING with streak=0.
- locked=1 exactly while the FSM is in LOCKED.
- Flagging an error: err_pulse<=1 for one cycle, err_code<=type, err_sticky<=1, err_cnt<=err_cnt+1 (saturating at 2^ERR_CNT_W-1).
- A correct sample sets err_code<=0.
- clr_err and an error on the same edge: the new error wins, giving err_sticky=1 and err_cnt=1. clr_err alone gives err_sticky=0 and err_cnt=0.
- A repeated identical one-hot value (stalled counter) is a STEP error.

Decomposition:
- Shared package ring_pkg holds:
  - err_code localparams: ERR_NONE, ERR_ZERO, ERR_MULTI, ERR_STEP.
  - FSM state enum: HUNT, LOCKING, LOCKED.
- One natural sub-module: onehot_decode, a combinational block that produces idx_new, is_zero and is_multi from q_in.
- FSM, counters and registers stay in the top module.

Test Plan:
- Reset: rst=1 → all outputs 0. Then q_in=0001, 0010, 0100, 1000, 0001 with en=1 → idx=0,1,2,3,0; locked=1 after the 4th sample (3 correct steps); err_cnt=0.
- Stuck-at-zero counter: q_in=0000 for 5 enabled cycles → 5 err_pulses, err_code=1, err_cnt=5, locked=0, idx_valid=0.
- While locked, q_in jumps 0010→1000 → err_code=3, err_pulse=1, locked=0. Then continuing 0001, 0010, 0100, 1000 → relocks after 3 more correct steps.
- q_in=0110 while locked → err_code=2, FSM=HUNT, idx holds at its previous value.
- en toggling: en=0 for 3 cycles during a correct sequence with garbage on q_in → no errors and state holds. clr_err on the same edge as a ZERO error → err_cnt=1, err_sticky=1.
- ERR_CNT_W=2 with 5 consecutive ZERO samples → err_cnt saturates at 3. Assert rst mid-sequence → immediate return to all-zero outputs.
